cache_controller: RTL and testbench
===================================

// Module: cache_controller
// PURPOSE
//  Miss-handling FSM for the 8-line, direct-mapped, write-back data cache (128-bit blocks).
//  Detects read/write misses and drives the block-level data-memory interface.
//  Issues a dirty-victim write-back first when needed, then the block refill.
//  Holds the CPU stalled through its busywait output until the refill completes.
//  Sits inside the data cache, between its tag/valid/dirty arrays and the main data memory.
// PARAMETERS
//  TAG_W    25  tag width (address[31:7])
//  IDX_W    3   index width (address[6:4]), 8 lines
//  BLOCK_W  128 block width; mem_address width = TAG_W+IDX_W = 28
// PORTS
//  clock          in   1    single clock; all state changes on posedge
//  reset          in   1    synchronous, active-low reset
//  read           in   1    CPU read request
//  write          in   1    CPU write request
//  busywait       out  1    controller stall request, ORed with the cache's own busywait
//  mem_busywait   in   1    data memory busy; high while a block transfer is in flight
//  wb_tag         in   25   tag of the resident (victim) line at index
//  wb_data        in   128  block data of the resident (victim) line
//  tag            in   25   tag of the current request
//  index          in   3    line index of the current request
//  hit            in   1    tag match AND valid for the current request
//  dirty          in   1    dirty bit of the line at index
//  mem_read       out  1    block read strobe to data memory
//  mem_write      out  1    block write strobe to data memory
//  mem_writedata  out  128  block written back to memory
//  mem_address    out  28   block address {tag,index}
// BEHAVIOUR
//  - States: IDLE, WRITE_BACK, MEM_READ. Moore outputs from the registered state.
//  - Exception: busywait has a Mealy term so a miss stalls the CPU in the detection cycle.
//  - Miss = (read|write) & !hit.
//  - IDLE: on a miss, capture tag, index, wb_tag, wb_data into internal registers.
//    - dirty=1 -> WRITE_BACK.
//    - dirty=0 -> MEM_READ.
//    - Otherwise stay in IDLE.
//  - WRITE_BACK: mem_write=1, mem_read=0.
//    - mem_address = {captured wb_tag, captured index}; mem_writedata = captured wb_data.
//    - Exits to MEM_READ on a posedge with mem_busywait=0.
//  - MEM_READ: mem_read=1, mem_write=0, mem_address = {captured tag, captured index}.
//    - Exits to IDLE on a posedge with mem_busywait=0.
//    - The cache array installs the block itself on the mem_busywait fall; the controller does not.
//  - mem_busywait is ignored in the first cycle of each memory state.
//    - Memory must raise it within one cycle of the strobe and hold it until its data is done.
//  - busywait = 1 in WRITE_BACK and MEM_READ, and in IDLE while a miss is present; 0 otherwise.
//  - In IDLE: mem_read=0, mem_write=0, mem_address=0, mem_writedata=0.
//  - Strobes never overlap; both drop for at least the IDLE cycle between requests.
//  - Request inputs are sampled only at the IDLE miss edge.
//    - Changes to tag, index, read or write mid-transfer have no effect.
//    - A request dropped mid-transfer does not abort the transfer.
//  - Simultaneous read & write: treated as a request (miss test applies).
//  - Hit with dirty=1: no action, stays IDLE.
//  - Reset (reset==0 at posedge): state=IDLE, all captured registers cleared.
//    - All outputs 0, from the cycle after the reset edge.
//    - Applies mid-transfer: the transfer is abandoned and strobes drop.
// TESTING
//  - Reset: reset=0 for 2 cycles during MEM_READ -> state IDLE, mem_read=0, busywait=0.
//  - Read hit: read=1, hit=1, dirty=1 -> busywait=0, no strobes, stays IDLE.
//  - Clean read miss: tag=25'h12, index=3, hit=0, dirty=0 -> busywait=1 the same cycle.
//    - Next edge: mem_read=1, mem_address=28'h0000093.
//    - Mem busy 5 cycles then low -> IDLE on that edge, busywait=0.
//  - Dirty write miss: write=1, wb_tag=25'h5, index=3, wb_data=128'hDEAD..BEEF.
//    - mem_write=1, mem_address=28'h000002B, mem_writedata=wb_data.
//    - After mem_busywait falls: mem_read=1, mem_address={tag,3}.
//  - Input change mid-transfer: change tag/index during MEM_READ -> mem_address stays at the captured value.
//  - Back-to-back misses: a second miss right after returning to IDLE starts a new refill.
//    - Exactly one IDLE cycle with both strobes low in between.

Source files
------------

// File: rtl/cache_controller.sv
// Miss-handling controller for an 8-line direct-mapped write-back data cache.
// On a miss it writes back the dirty victim block if needed, then refills the
// line, and keeps the CPU stalled until the refill completes.
module cache_controller #(
    parameter int TAG_W   = 25,
    parameter int IDX_W   = 3,
    parameter int BLOCK_W = 128
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   read,
    input  logic                   write,
    output logic                   busywait,
    input  logic                   mem_busywait,
    input  logic [TAG_W-1:0]       wb_tag,
    input  logic [BLOCK_W-1:0]     wb_data,
    input  logic [TAG_W-1:0]       tag,
    input  logic [IDX_W-1:0]       index,
    input  logic                   hit,
    input  logic                   dirty,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [BLOCK_W-1:0]     mem_writedata,
    output logic [TAG_W+IDX_W-1:0] mem_address
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WRITE_BACK = 2'd1,
        S_MEM_READ   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [TAG_W-1:0]     r_tag;
    logic [TAG_W-1:0]     r_wb_tag;
    logic [IDX_W-1:0]     r_index;
    logic [BLOCK_W-1:0]   r_wb_data;
    logic                 r_first;     // first cycle of a memory state
    logic                 w_miss;
    logic                 w_mem_done;
    logic                 w_capture;

    // A request held during reset must not raise the stall output.
    assign w_miss     = reset & (read | write) & ~hit;
    // Memory busy is not trusted in the strobe's first cycle: it may still be rising.
    assign w_mem_done = ~r_first & ~mem_busywait;
    assign w_capture  = (r_state == S_IDLE) & w_miss;

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Flag the first cycle after entering WRITE_BACK or MEM_READ.
    always_ff @(posedge clock) begin
        if (!reset) r_first <= 1'b0;
        else        r_first <= (w_next != r_state) && (w_next != S_IDLE);
    end

    // Snapshot the request and victim at the miss edge; held for the whole transfer.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_tag     <= '0;
            r_wb_tag  <= '0;
            r_index   <= '0;
            r_wb_data <= '0;
        end else if (w_capture) begin
            r_tag     <= tag;
            r_wb_tag  <= wb_tag;
            r_index   <= index;
            r_wb_data <= wb_data;
        end
    end

    // Next state and Moore outputs; busywait also carries the IDLE miss term.
    always_comb begin
        w_next        = r_state;
        busywait      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        case (r_state)
            S_IDLE: begin
                busywait = w_miss;
                if (w_miss) w_next = dirty ? S_WRITE_BACK : S_MEM_READ;
            end
            S_WRITE_BACK: begin
                busywait      = 1'b1;
                mem_write     = 1'b1;
                mem_address   = {r_wb_tag, r_index};
                mem_writedata = r_wb_data;
                if (w_mem_done) w_next = S_MEM_READ;
            end
            S_MEM_READ: begin
                busywait    = 1'b1;
                mem_read    = 1'b1;
                mem_address = {r_tag, r_index};
                if (w_mem_done) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller: the stimulus side predicts the memory
// transactions each request should cause, a monitor pops and checks them as
// the strobes appear, and a simple memory model answers with random latency.
module tb_cache_controller;

    logic          clock = 1'b0;
    logic          reset;
    logic          read, write, hit, dirty;
    logic          busywait;
    logic          mem_busywait;
    logic [24:0]   wb_tag, tag;
    logic [127:0]  wb_data;
    logic [2:0]    index;
    logic          mem_read, mem_write;
    logic [127:0]  mem_writedata;
    logic [27:0]   mem_address;

    typedef struct {
        bit           wr;
        logic [27:0]  addr;
        logic [127:0] data;
    } xact_t;

    xact_t sb[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    mem_lat = -1;   // -1: random memory latency

    cache_controller dut (
        .clock(clock), .reset(reset), .read(read), .write(write),
        .busywait(busywait), .mem_busywait(mem_busywait),
        .wb_tag(wb_tag), .wb_data(wb_data), .tag(tag), .index(index),
        .hit(hit), .dirty(dirty), .mem_read(mem_read), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_address(mem_address)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s", nm);
    endtask

    // Memory model: goes busy when a new block strobe appears, stays busy a few cycles.
    initial begin : mem_model
        bit p_rd, p_wr;
        int cnt;
        p_rd = 0; p_wr = 0; cnt = 0;
        mem_busywait = 1'b0;
        forever begin
            @(negedge clock);
            if ((mem_read && !p_rd) || (mem_write && !p_wr)) begin
                mem_busywait = 1'b1;
                cnt = (mem_lat >= 0) ? mem_lat : int'($urandom_range(0, 4));
            end else if (mem_busywait) begin
                if (cnt == 0) mem_busywait = 1'b0;
                else          cnt--;
            end
            p_rd = mem_read;
            p_wr = mem_write;
        end
    end

    // Monitor: checks each new transaction against the scoreboard and that
    // address/data stay put for its duration; idle outputs must be zero.
    initial begin : monitor
        bit    p_rd, p_wr;
        xact_t cur, e;
        p_rd = 0; p_wr = 0;
        cur = '{wr: 1'b0, addr: 28'h0, data: 128'h0};
        forever begin
            @(negedge clock);
            if (reset === 1'b1) begin
                chk("strobe_overlap", mem_read & mem_write, 0);
                if ((mem_read && !p_rd) || (mem_write && !p_wr)) begin
                    if (sb.size() == 0) begin
                        fail_now("unexpected_transaction");
                    end else begin
                        e = sb.pop_front();
                        cur = e;
                        chk("xact_kind", mem_write, e.wr);
                        chk("xact_addr", mem_address, e.addr);
                        if (e.wr) chk("xact_wdata", mem_writedata, e.data);
                    end
                end else if (mem_read || mem_write) begin
                    chk("addr_hold", mem_address, cur.addr);
                    if (cur.wr) chk("wdata_hold", mem_writedata, cur.data);
                end else begin
                    chk("idle_addr", mem_address, 0);
                    chk("idle_wdata", mem_writedata, 0);
                end
            end
            p_rd = mem_read;
            p_wr = mem_write;
        end
    end

    // One CPU access. For a miss the request is dropped after the miss edge,
    // which must not abort the transfer; optionally the request inputs are
    // scrambled mid-transfer as well.
    task automatic req(input bit rd, input bit wr, input bit h, input bit d,
                       input logic [24:0] t, input logic [2:0] ix,
                       input logic [24:0] wt, input logic [127:0] wd,
                       input bit scramble);
        bit miss;
        int n;
        @(negedge clock);
        read = rd; write = wr; hit = h; dirty = d;
        tag = t; index = ix; wb_tag = wt; wb_data = wd;
        miss = (rd || wr) && !h;
        if (miss) begin
            if (d) sb.push_back('{wr: 1'b1, addr: {wt, ix}, data: wd});
            sb.push_back('{wr: 1'b0, addr: {t, ix}, data: 128'h0});
        end
        #1 chk("busywait_detect", busywait, miss);
        @(negedge clock);
        if (!miss) begin
            chk("nomiss_strobes", {mem_read, mem_write}, 2'b00);
            chk("nomiss_busywait", busywait, 0);
            return;
        end
        chk("miss_strobe", {mem_read, mem_write}, d ? 2'b01 : 2'b10);
        read = 0; write = 0;
        n = 0;
        while (busywait === 1'b1 && n < 200) begin
            if (scramble) begin
                tag = 25'($urandom); index = 3'($urandom);
                wb_tag = 25'($urandom); wb_data = {$urandom, $urandom, $urandom, $urandom};
                dirty = 1'($urandom);
            end
            @(negedge clock);
            n++;
        end
        if (busywait !== 1'b0) fail_now("transfer_timeout");
        chk("done_strobes", {mem_read, mem_write}, 2'b00);
    endtask

    initial begin : stim
        int n, idle;
        reset = 0; read = 0; write = 0; hit = 0; dirty = 0;
        tag = 0; index = 0; wb_tag = 0; wb_data = 0;

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_busywait", busywait, 0);
        chk("rst_strobes", {mem_read, mem_write}, 2'b00);
        chk("rst_addr", mem_address, 0);
        chk("rst_wdata", mem_writedata, 0);
        reset = 1;

        // Read hit on a dirty line: nothing happens
        req(1, 0, 1, 1, 25'h12, 3'd3, 25'h5, 128'h1, 0);

        // Clean read miss, memory busy for five cycles
        mem_lat = 4;
        req(1, 0, 0, 0, 25'h12, 3'd3, 25'h0, 128'h0, 0);
        mem_lat = -1;

        // Dirty write miss: write-back then refill, inputs scrambled mid-transfer
        req(0, 1, 0, 1, 25'h77, 3'd3, 25'h5,
            128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF, 1);

        // Simultaneous read and write
        req(1, 1, 0, 0, 25'h1ABCDEF, 3'd7, 25'h3, 128'h0, 0);

        // Back-to-back misses with the tag changed mid-refill
        @(negedge clock);
        read = 1; write = 0; hit = 0; dirty = 0; tag = 25'h100; index = 3'd5;
        sb.push_back('{wr: 1'b0, addr: {25'h100, 3'd5}, data: 128'h0});
        sb.push_back('{wr: 1'b0, addr: {25'h200, 3'd5}, data: 128'h0});
        @(negedge clock);
        tag = 25'h200;
        n = 0;
        while (mem_read === 1'b1 && n < 100) begin @(negedge clock); n++; end
        chk("b2b_idle_busywait", busywait, 1);
        idle = 0;
        while (mem_read !== 1'b1 && n < 100) begin idle++; @(negedge clock); n++; end
        chk("b2b_idle_cycles", idle, 1);
        read = 0;
        while (busywait === 1'b1 && n < 200) begin @(negedge clock); n++; end
        if (busywait !== 1'b0) fail_now("b2b_timeout");

        // Reset during MEM_READ abandons the refill
        mem_lat = 10;
        @(negedge clock);
        read = 1; hit = 0; dirty = 0; tag = 25'h42; index = 3'd1;
        sb.push_back('{wr: 1'b0, addr: {25'h42, 3'd1}, data: 128'h0});
        repeat (2) @(negedge clock);
        chk("pre_rst_mem_read", mem_read, 1);
        reset = 0; read = 0;
        @(negedge clock);
        chk("mid_rst_mem_read", mem_read, 0);
        chk("mid_rst_busywait", busywait, 0);
        chk("mid_rst_addr", mem_address, 0);
        @(negedge clock);
        reset = 1;
        sb.delete();
        mem_lat = -1;
        repeat (14) @(negedge clock);

        // Randomized traffic against the transaction-level model
        for (int i = 0; i < 150; i++) begin
            req(1'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0), 1'($urandom),
                25'($urandom), 3'($urandom), 25'($urandom),
                {$urandom, $urandom, $urandom, $urandom}, 1'($urandom));
        end

        repeat (5) @(negedge clock);
        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
